// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader
// Brief    : Receives a program image over an 8N1 UART line, assembles the
//            bytes into 32-bit little-endian words and drives the
//            instruction-memory programming port (wen/addr/data/done).
//            Frame = 16-bit word count N (LSB first), then 4*N data bytes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 87,  // UART bit period in clock cycles, >= 4
  parameter int ADDR_W       = 14   // instruction-memory word-address width, 1..16
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              rx_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_addr_o,
  output logic [31:0]       upg_data_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  // Largest accepted word count, 2^ADDR_W, kept one bit wider than N.
  localparam logic [16:0]       MAX_WORDS = 17'd1 << ADDR_W;

  // --------------------------------------------------------------------------
  // RX front end
  // --------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_prev_q;
  logic start_edge_w;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign start_edge_w = rx_prev_q & ~rx_sync_q;

  // --------------------------------------------------------------------------
  // RX byte FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  rx_state_t        rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic             byte_valid_q;
  logic             frame_err_q;

  // Mid-bit sampling receiver; byte_valid/frame_err are single-cycle pulses.
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      rx_state_q   <= R_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_state_q)
        R_IDLE: begin
          rx_cnt_q <= '0;
          rx_bit_q <= 3'd0;
          if (start_edge_w) begin
            rx_state_q <= R_START;
          end
        end
        R_START: begin
          // Re-check the line half a bit in; a high line means it was a glitch.
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        R_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= R_STOP;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        R_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= R_IDLE;
            if (rx_sync_q) begin
              byte_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          rx_state_q <= R_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Loader FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    L_HDR0 = 3'd0,
    L_HDR1 = 3'd1,
    L_WORD = 3'd2,
    L_DONE = 3'd3,
    L_ERR  = 3'd4
  } ld_state_t;

  ld_state_t         ld_state_q;
  logic [15:0]       n_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [1:0]        idx_q;
  logic [23:0]       part_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              done_q;
  logic              busy_q;
  logic              err_q;

  logic [15:0]       n_full_w;
  logic              last_word_w;

  // Word count as it stands once the second header byte arrives.
  assign n_full_w    = {rx_shift_q, n_q[7:0]};
  // Counter is one bit wider than the address so N = 2^ADDR_W does not wrap.
  assign last_word_w = (17'(wcnt_q) == {1'b0, n_q});

  // Header decode, little-endian word assembly and write/done sequencing.
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      ld_state_q <= L_HDR0;
      n_q        <= 16'd0;
      wcnt_q     <= '0;
      idx_q      <= 2'd0;
      part_q     <= 24'd0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= 32'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      if (frame_err_q) begin
        err_q <= 1'b1;
      end
      case (ld_state_q)
        L_HDR0: begin
          if (frame_err_q) begin
            ld_state_q <= L_ERR;
            busy_q     <= 1'b0;
          end else if (byte_valid_q) begin
            n_q[7:0]   <= rx_shift_q;
            busy_q     <= 1'b1;
            ld_state_q <= L_HDR1;
          end
        end
        L_HDR1: begin
          if (frame_err_q) begin
            ld_state_q <= L_ERR;
            busy_q     <= 1'b0;
          end else if (byte_valid_q) begin
            n_q[15:8] <= rx_shift_q;
            if (n_full_w == 16'd0) begin
              ld_state_q <= L_DONE;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
            end else if ({1'b0, n_full_w} > MAX_WORDS) begin
              ld_state_q <= L_ERR;
              err_q      <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              ld_state_q <= L_WORD;
              wcnt_q     <= '0;
              idx_q      <= 2'd0;
            end
          end
        end
        L_WORD: begin
          if (frame_err_q) begin
            ld_state_q <= L_ERR;
            busy_q     <= 1'b0;
          end else if (wen_q && last_word_w) begin
            // Final write has just been presented; done follows it by a cycle.
            ld_state_q <= L_DONE;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
          end else if (byte_valid_q) begin
            if (idx_q == 2'd3) begin
              wen_q  <= 1'b1;
              addr_q <= wcnt_q[ADDR_W-1:0];
              data_q <= {rx_shift_q, part_q};
              wcnt_q <= wcnt_q + (ADDR_W+1)'(1);
              idx_q  <= 2'd0;
            end else begin
              case (idx_q)
                2'd0:    part_q[7:0]   <= rx_shift_q;
                2'd1:    part_q[15:8]  <= rx_shift_q;
                default: part_q[23:16] <= rx_shift_q;
              endcase
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        L_DONE: begin
          // Terminal until reset; further bytes are ignored.
        end
        L_ERR: begin
          // Terminal until reset; further bytes are ignored.
        end
        default: begin
          ld_state_q <= L_ERR;
        end
      endcase
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_addr_o = addr_q;
  assign upg_data_o = data_q;
  assign upg_done_o = done_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_prog_loader
// Brief    : Self-checking bench for uart_prog_loader. Two instances: one with
//            a 14-bit address, one with a 4-bit address for the size limits.
//            Expected writes come from a byte-stream model of the frame format.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_prog_loader;

  localparam int CPB  = 4;
  localparam int AW_A = 14;
  localparam int AW_B = 4;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  int   cyc  = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic            wen_a, done_a, busy_a, err_a;
  logic [AW_A-1:0] addr_a;
  logic [31:0]     data_a;
  logic            wen_b, done_b, busy_b, err_b;
  logic [AW_B-1:0] addr_b;
  logic [31:0]     data_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW_A)) dut_a (
    .upg_clk_i(clk), .upg_rst_i(rst), .rx_i(rx_a),
    .upg_wen_o(wen_a), .upg_addr_o(addr_a), .upg_data_o(data_a),
    .upg_done_o(done_a), .busy_o(busy_a), .err_o(err_a)
  );

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW_B)) dut_b (
    .upg_clk_i(clk), .upg_rst_i(rst), .rx_i(rx_b),
    .upg_wen_o(wen_b), .upg_addr_o(addr_b), .upg_data_o(data_b),
    .upg_done_o(done_b), .busy_o(busy_b), .err_o(err_b)
  );

  // Observed writes and edge times, collected on the falling edge.
  int          wa_addr[$], wa_cyc[$], wb_addr[$], wb_cyc[$];
  logic [31:0] wa_data[$], wb_data[$];
  int          a_done_cyc, a_busy_fall_cyc, b_done_cyc;
  logic        a_done_prev, a_busy_prev, b_done_prev;

  always @(negedge clk) begin
    if (wen_a === 1'b1) begin
      wa_addr.push_back(int'(addr_a)); wa_data.push_back(data_a); wa_cyc.push_back(cyc);
    end
    if (done_a === 1'b1 && a_done_prev !== 1'b1) a_done_cyc = cyc;
    if (busy_a !== 1'b1 && a_busy_prev === 1'b1) a_busy_fall_cyc = cyc;
    a_done_prev = done_a;
    a_busy_prev = busy_a;
    if (wen_b === 1'b1) begin
      wb_addr.push_back(int'(addr_b)); wb_data.push_back(data_b); wb_cyc.push_back(cyc);
    end
    if (done_b === 1'b1 && b_done_prev !== 1'b1) b_done_cyc = cyc;
    b_done_prev = done_b;
  end

  // Stimulus log and reference-model results.
  logic [7:0]  tx_bytes[$];
  bit          tx_ok[$];
  int          ex_addr[$];
  logic [31:0] ex_data[$];
  bit          ex_done, ex_err;
  int          last_start_cyc;

  task automatic do_reset();
    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (3) @(negedge clk);
    tx_bytes.delete(); tx_ok.delete();
    wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
    wb_addr.delete(); wb_data.delete(); wb_cyc.delete();
    a_done_cyc = -1; a_busy_fall_cyc = -1; b_done_cyc = -1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Drive one 8N1 frame on the selected line (sel=1 -> instance B).
  task automatic send_byte(input bit sel, input logic [7:0] b, input bit good);
    logic [9:0] frame;
    frame = {good, b, 1'b0};
    tx_bytes.push_back(b);
    tx_ok.push_back(good);
    last_start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      if (sel) rx_b = frame[i]; else rx_a = frame[i];
      repeat (CPB) @(negedge clk);
    end
    if (sel) rx_b = 1'b1; else rx_a = 1'b1;
    repeat (CPB + int'($urandom_range(0, 6))) @(negedge clk);
  endtask

  // Frame interpretation of the logged byte stream: header, words, limits.
  task automatic model_run(input int aw);
    int          p, n, k, j;
    logic [31:0] w;
    bit          halt;
    ex_addr.delete(); ex_data.delete();
    ex_done = 0; ex_err = 0; p = 0; n = 0; w = 0; halt = 0;
    foreach (tx_bytes[i]) begin
      if (!tx_ok[i]) begin
        ex_err = 1;
        halt   = 1;
      end else if (!halt) begin
        if (p == 0) begin
          n = int'(tx_bytes[i]);
        end else if (p == 1) begin
          n = n + int'(tx_bytes[i]) * 256;
          if (n == 0) begin ex_done = 1; halt = 1; end
          else if (n > (1 << aw)) begin ex_err = 1; halt = 1; end
        end else begin
          k = (p - 2) / 4;
          j = (p - 2) % 4;
          w[8*j +: 8] = tx_bytes[i];
          if (j == 3) begin
            ex_addr.push_back(k);
            ex_data.push_back(w);
            w = 0;
            if (k + 1 == n) begin ex_done = 1; halt = 1; end
          end
        end
        p++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({wen_a, done_a, busy_a, err_a} !== 4'b0) begin n_bad++; $display("FAIL reset_flags_a: got %b expected 0000", {wen_a, done_a, busy_a, err_a}); end
    n_cmp++; if ({addr_a, data_a} !== '0) begin n_bad++; $display("FAIL reset_addr_data_a: got %0h/%0h expected 0/0", addr_a, data_a); end
    n_cmp++; if ({wen_b, done_b, busy_b, err_b, addr_b, data_b} !== '0) begin n_bad++; $display("FAIL reset_all_b: got nonzero outputs, expected all 0"); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if ({wen_a, done_a, busy_a, err_a} !== 4'b0) begin n_bad++; $display("FAIL idle_after_reset_a: got %b expected 0000", {wen_a, done_a, busy_a, err_a}); end
  endtask

  task automatic test_two_words();
    logic [7:0] pl[8];
    pl = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    do_reset();
    send_byte(0, 8'h02, 1);
    send_byte(0, 8'h00, 1);
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL two_words_busy_hdr: got %b expected 1", busy_a); end
    for (int i = 0; i < 8; i++) send_byte(0, pl[i], 1);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (wa_addr.size() != 2) begin
      n_bad++; $display("FAIL two_words_count: got %0d writes expected 2", wa_addr.size());
    end else begin
      n_cmp++; if (wa_addr[0] != 0 || wa_data[0] !== 32'h00100513) begin n_bad++; $display("FAIL two_words_w0: got %0d/%08h expected 0/00100513", wa_addr[0], wa_data[0]); end
      n_cmp++; if (wa_addr[1] != 1 || wa_data[1] !== 32'h0000006F) begin n_bad++; $display("FAIL two_words_w1: got %0d/%08h expected 1/0000006f", wa_addr[1], wa_data[1]); end
      n_cmp++; if (wa_cyc[1] - wa_cyc[0] < 2) begin n_bad++; $display("FAIL two_words_pulse: got gap %0d expected >=2", wa_cyc[1] - wa_cyc[0]); end
      n_cmp++; if (a_done_cyc != wa_cyc[1] + 1) begin n_bad++; $display("FAIL two_words_done_time: got %0d expected %0d", a_done_cyc, wa_cyc[1] + 1); end
    end
    n_cmp++; if (a_busy_fall_cyc != a_done_cyc) begin n_bad++; $display("FAIL two_words_busy_fall: got %0d expected %0d", a_busy_fall_cyc, a_done_cyc); end
    n_cmp++; if ({done_a, err_a} !== 2'b10) begin n_bad++; $display("FAIL two_words_flags: got done/err %b expected 10", {done_a, err_a}); end
    n_cmp++; if (addr_a !== 14'd1 || data_a !== 32'h6F) begin n_bad++; $display("FAIL two_words_hold: got %0h/%0h expected 1/6f", addr_a, data_a); end
  endtask

  task automatic test_zero_len();
    int lo, hi;
    do_reset();
    send_byte(0, 8'h00, 1);
    send_byte(0, 8'h00, 1);
    lo = last_start_cyc + 9 * CPB + CPB / 2 + 1;
    hi = last_start_cyc + 10 * CPB + 4;
    n_cmp++; if (a_done_cyc < lo || a_done_cyc > hi) begin n_bad++; $display("FAIL zero_len_done_time: got %0d expected %0d..%0d", a_done_cyc, lo, hi); end
    for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom), 1);
    repeat (8) @(negedge clk);
    n_cmp++; if (wa_addr.size() != 0) begin n_bad++; $display("FAIL zero_len_writes: got %0d expected 0", wa_addr.size()); end
    n_cmp++; if ({done_a, busy_a, err_a} !== 3'b100) begin n_bad++; $display("FAIL zero_len_flags: got %b expected 100", {done_a, busy_a, err_a}); end
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(1, 8'h11, 1);
    send_byte(1, 8'h00, 1);
    for (int i = 0; i < 8; i++) send_byte(1, 8'($urandom), 1);
    repeat (8) @(negedge clk);
    model_run(AW_B);
    n_cmp++; if (wb_addr.size() != ex_addr.size()) begin n_bad++; $display("FAIL oversize_writes: got %0d expected %0d", wb_addr.size(), ex_addr.size()); end
    n_cmp++; if ({done_b, busy_b, err_b} !== {ex_done, 1'b0, ex_err}) begin n_bad++; $display("FAIL oversize_flags: got %b expected %b", {done_b, busy_b, err_b}, {ex_done, 1'b0, ex_err}); end
  endtask

  task automatic test_full_aw4();
    do_reset();
    send_byte(1, 8'h10, 1);
    send_byte(1, 8'h00, 1);
    for (int i = 0; i < 64; i++) send_byte(1, 8'($urandom), 1);
    repeat (8) @(negedge clk);
    model_run(AW_B);
    n_cmp++;
    if (wb_addr.size() != ex_addr.size()) begin
      n_bad++; $display("FAIL full_aw4_count: got %0d expected %0d", wb_addr.size(), ex_addr.size());
    end else begin
      foreach (ex_addr[i]) begin
        n_cmp++;
        if (wb_addr[i] != ex_addr[i] || wb_data[i] !== ex_data[i]) begin
          n_bad++; $display("FAIL full_aw4_w%0d: got %0d/%08h expected %0d/%08h", i, wb_addr[i], wb_data[i], ex_addr[i], ex_data[i]);
        end
      end
      n_cmp++; if (b_done_cyc != wb_cyc[wb_cyc.size()-1] + 1) begin n_bad++; $display("FAIL full_aw4_done_time: got %0d expected %0d", b_done_cyc, wb_cyc[wb_cyc.size()-1] + 1); end
    end
    n_cmp++; if ({done_b, err_b} !== {ex_done, ex_err}) begin n_bad++; $display("FAIL full_aw4_flags: got %b expected %b", {done_b, err_b}, {ex_done, ex_err}); end
  endtask

  task automatic test_framing_err();
    do_reset();
    send_byte(0, 8'h01, 1);
    send_byte(0, 8'h00, 1);
    send_byte(0, 8'($urandom), 0);
    for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom), 1);
    repeat (8) @(negedge clk);
    model_run(AW_A);
    n_cmp++; if (wa_addr.size() != ex_addr.size()) begin n_bad++; $display("FAIL framing_writes: got %0d expected %0d", wa_addr.size(), ex_addr.size()); end
    n_cmp++; if ({done_a, busy_a, err_a} !== {ex_done, 1'b0, ex_err}) begin n_bad++; $display("FAIL framing_flags: got %b expected %b", {done_a, busy_a, err_a}, {ex_done, 1'b0, ex_err}); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] pl[6];
    pl = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    send_byte(0, 8'h01, 1);
    send_byte(0, 8'h00, 1);
    send_byte(0, 8'h55, 1);
    send_byte(0, 8'hAA, 1);
    n_cmp++; if (wa_addr.size() != 0) begin n_bad++; $display("FAIL midframe_early_write: got %0d expected 0", wa_addr.size()); end
    do_reset();
    n_cmp++; if ({wen_a, done_a, busy_a, err_a} !== 4'b0) begin n_bad++; $display("FAIL midframe_cleared: got %b expected 0000", {wen_a, done_a, busy_a, err_a}); end
    for (int i = 0; i < 6; i++) send_byte(0, pl[i], 1);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (wa_addr.size() != 1) begin
      n_bad++; $display("FAIL midframe_count: got %0d expected 1", wa_addr.size());
    end else begin
      n_cmp++; if (wa_addr[0] != 0 || wa_data[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL midframe_word: got %0d/%08h expected 0/deadbeef", wa_addr[0], wa_data[0]); end
    end
    n_cmp++; if ({done_a, err_a} !== 2'b10) begin n_bad++; $display("FAIL midframe_flags: got %b expected 10", {done_a, err_a}); end
  endtask

  task automatic test_glitch();
    do_reset();
    rx_a = 1'b0;
    @(negedge clk);
    rx_a = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++; if ({wen_a, done_a, busy_a, err_a} !== 4'b0 || wa_addr.size() != 0) begin n_bad++; $display("FAIL glitch_idle: got flags %b writes %0d expected 0000/0", {wen_a, done_a, busy_a, err_a}, wa_addr.size()); end
    send_byte(0, 8'h01, 1);
    send_byte(0, 8'h00, 1);
    for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom), 1);
    repeat (8) @(negedge clk);
    model_run(AW_A);
    n_cmp++;
    if (wa_addr.size() != 1) begin
      n_bad++; $display("FAIL glitch_then_frame_count: got %0d expected 1", wa_addr.size());
    end else begin
      n_cmp++; if (wa_addr[0] != ex_addr[0] || wa_data[0] !== ex_data[0]) begin n_bad++; $display("FAIL glitch_then_frame_word: got %0d/%08h expected %0d/%08h", wa_addr[0], wa_data[0], ex_addr[0], ex_data[0]); end
    end
  endtask

  task automatic test_random_frames();
    int n;
    for (int f = 0; f < 4; f++) begin
      do_reset();
      n = int'($urandom_range(1, 5));
      send_byte(0, 8'(n), 1);
      send_byte(0, 8'h00, 1);
      for (int i = 0; i < 4 * n; i++) send_byte(0, 8'($urandom), 1);
      repeat (8) @(negedge clk);
      model_run(AW_A);
      n_cmp++;
      if (wa_addr.size() != ex_addr.size()) begin
        n_bad++; $display("FAIL rand%0d_count: got %0d expected %0d", f, wa_addr.size(), ex_addr.size());
      end else begin
        foreach (ex_addr[i]) begin
          n_cmp++;
          if (wa_addr[i] != ex_addr[i] || wa_data[i] !== ex_data[i]) begin
            n_bad++; $display("FAIL rand%0d_w%0d: got %0d/%08h expected %0d/%08h", f, i, wa_addr[i], wa_data[i], ex_addr[i], ex_data[i]);
          end
        end
        n_cmp++; if (a_done_cyc != wa_cyc[wa_cyc.size()-1] + 1) begin n_bad++; $display("FAIL rand%0d_done_time: got %0d expected %0d", f, a_done_cyc, wa_cyc[wa_cyc.size()-1] + 1); end
      end
      n_cmp++; if (a_busy_fall_cyc != a_done_cyc) begin n_bad++; $display("FAIL rand%0d_busy_fall: got %0d expected %0d", f, a_busy_fall_cyc, a_done_cyc); end
      n_cmp++; if ({done_a, err_a} !== {ex_done, ex_err}) begin n_bad++; $display("FAIL rand%0d_flags: got %b expected %b", f, {done_a, err_a}, {ex_done, ex_err}); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_two_words();
    test_zero_len();
    test_oversize();
    test_full_aw4();
    test_framing_err();
    test_reset_midframe();
    test_glitch();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream feeder of the instruction-memory programming port. It receives a program image over an 8N1 UART line and assembles bytes into 32-bit little-endian words.
- It drives the upg_wen/upg_addr/upg_data/upg_done inputs of the fetch stage while the CPU is held in programming mode.
- The whole block runs in the UPG clock domain (10 MHz).

Parameters:
- CLKS_PER_BIT, 87, UART bit period in upg_clk_i cycles (10 MHz / 115200); minimum 4.
- ADDR_W, 14, word-address width of the instruction memory.

Ports:
- upg_clk_i  input  1  UPG clock.
- upg_rst_i  input  1  synchronous active-high reset.
- rx_i  input  1  asynchronous UART receive line, idle high.
- upg_wen_o  output  1  one-cycle write strobe to instruction memory.
- upg_addr_o  output  ADDR_W  word address of the current write.
- upg_data_o  output  32  word data of the current write.
- upg_done_o  output  1  program fully loaded; sticky until reset.
- busy_o  output  1  frame in progress (header or words pending).
- err_o  output  1  sticky error (framing error or oversize header).

Behaviour:
- Clock and reset:
  - One clock, upg_clk_i. Reset is synchronous and active-high on upg_rst_i.
  - Reset values: all outputs 0; upg_addr_o 0; RX synchronizer flops 1.
- RX front end:
  - rx_i passes through a 2-flop synchronizer.
  - A start is detected on a synchronized 1->0 transition while the RX FSM is idle.
- RX FSM: R_IDLE -> R_START -> R_DATA -> R_STOP -> R_IDLE.
  - R_START: at CLKS_PER_BIT/2 (integer divide), re-sample the line. If high, treat as a glitch and return to R_IDLE. If low, proceed.
  - R_DATA: sample each of 8 bits every CLKS_PER_BIT cycles, LSB first.
  - R_STOP: sample the stop bit one period later.
  - Stop bit 1: emit byte_valid (internal, one cycle).
  - Stop bit 0: discard the byte, set err_o, return to R_IDLE.
- Loader FSM: L_HDR0 -> L_HDR1 -> L_WORD -> L_DONE, plus L_ERR.
  - L_HDR0: first byte is word-count N[7:0]. L_HDR1: second byte is N[15:8].
  - On N == 0: go to L_DONE.
  - On N > 2^ADDR_W: set err_o and go to L_ERR.
  - Otherwise go to L_WORD with word counter = 0 and byte index = 0.
  - L_WORD: each byte fills data[8*idx +: 8], idx 0..3 (little-endian).
  - On the 4th byte, in the cycle after its byte_valid:
    - upg_wen_o = 1 for exactly one cycle;
    - upg_addr_o = word counter (the first word goes to 0);
    - upg_data_o = the assembled word.
  - upg_addr_o and upg_data_o hold their values until the next write.
  - The word counter increments after each write. When it reaches N, go to L_DONE.
  - L_DONE: upg_done_o = 1 from the cycle after the final upg_wen_o pulse. For N = 0, it asserts from the cycle after the second header byte's byte_valid.
  - L_DONE and L_ERR ignore all further bytes until reset.
- busy_o = 1 from the first header byte's byte_valid until entry to L_DONE or L_ERR.
- A framing error in any loader state sends the loader to L_ERR. upg_done_o is never asserted afterwards.
- Simultaneous events:
  - A reset coinciding with byte_valid wins; the byte is lost.
  - A start edge during R_START, R_DATA or R_STOP is ignored.
- Reset mid-frame:
  - Partial word and counters are cleared; no write is issued.
  - The next received byte is treated as header byte 0.
- Width rules:
  - N is 16 bits and compared zero-extended against 2^ADDR_W.
  - The word counter is ADDR_W+1 bits wide, so N = 2^ADDR_W loads the last address 2^ADDR_W-1 without wrap.

Test Plan (CLKS_PER_BIT = 4, ADDR_W = 14 unless noted):
1. Send header 0x02,0x00 then bytes 0x13,0x05,0x10,0x00, 0x6F,0x00,0x00,0x00 -> write addr 0 data 0x00100513, then write addr 1 data 0x0000006F. Each upg_wen_o is exactly one cycle. upg_done_o rises the cycle after the 2nd write. busy_o falls on the same cycle.
2. Header 0x00,0x00 -> no upg_wen_o pulse; upg_done_o = 1 one cycle after the 2nd byte. Further bytes produce no writes.
3. With ADDR_W = 4, header 0x11,0x00 (N = 17) -> err_o = 1, no writes, upg_done_o stays 0. Header 0x10,0x00 with 16 words -> last write at addr 15, then done.
4. Header N = 1, then a byte with stop bit forced 0 -> err_o = 1, no write, loader ignores the remaining bytes.
5. Reset asserted after 2 of 4 data bytes, then a fresh frame with N = 1 and word 0xDEADBEEF -> single write at addr 0 with data 0xDEADBEEF, done asserted.
6. A 1-cycle low glitch on rx_i (shorter than CLKS_PER_BIT/2) -> no byte received, FSM remains idle, outputs unchanged.
